seq_div_wb: RTL and testbench
=============================

Name: seq_div_wb

Overview:
- Iterative multi-cycle integer divider in the EX stage of the pipelined CPU. It produces a quotient and remainder destined for the register file write port.
- Runs one restoring-division step per cycle.
- Holds its result and destination register number until the write-back stage grants the shared regfile write port (wb_ack).
- Asserts busy so hazard logic can stall dependent instructions.

Parameters:
- WIDTH, 32, operand/result width in bits.
- RW, 5, register-number width (matches regfile wn).

Ports:
- clk  input  1  rising-edge clock, same clock as regfile.
- clrn  input  1  asynchronous active-low reset.
- start  input  1  request a new division; sampled only when ready=1.
- is_signed  input  1  1 = two's-complement division, 0 = unsigned; captured with start.
- dividend  input  WIDTH  numerator; captured with start.
- divisor  input  WIDTH  denominator; captured with start.
- rd  input  RW  destination register number; captured with start.
- wb_ack  input  1  write-back has consumed the result this cycle.
- ready  output  1  idle and able to accept start.
- busy  output  1  operation in progress or result pending (not ready).
- valid  output  1  q/r/wn hold a finished result.
- q  output  WIDTH  quotient.
- r  output  WIDTH  remainder.
- wn  output  RW  captured destination register.
- div0  output  1  finished result came from a zero divisor.

Behaviour:
- Reset (clrn=0, asynchronous, any state including mid-operation):
  - state=IDLE; counter, working registers, q, r, wn all 0.
  - valid=0, div0=0, ready=1, busy=0.
  - Any in-flight division is discarded.
- States: IDLE, CALC, FIX, DONE. ready=(state==IDLE), busy=~ready.
- IDLE:
  - On edge with start=1, capture operands, rd and is_signed, then go to CALC with count=WIDTH-1.
  - In signed mode the working registers load the magnitudes |dividend| and |divisor|, computed as unsigned WIDTH bits so that -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - Record neg_q = signed & (sign(dividend) ^ sign(divisor)) and neg_r = signed & sign(dividend).
- CALC, one restoring step per edge:
  - Shift {rem,quo} left by 1.
  - Trial-subtract the divisor magnitude using a WIDTH+1-bit difference.
  - If non-negative, keep the difference and set the quotient LSB to 1.
  - When count==0, go to FIX; otherwise decrement count.
  - CALC lasts exactly WIDTH cycles.
- FIX, one cycle, loads q/r/div0 and goes to DONE with valid=1:
  - divisor==0: q = all ones, r = original dividend (unmodified), div0=1. Applies to both signed and unsigned.
  - otherwise: q = neg_q ? -quo : quo and r = neg_r ? -rem : rem, each modulo 2^WIDTH.
  - Signed overflow: -2^(WIDTH-1) / -1 gives q=0x80000000, r=0 with no special case.
- Latency: valid rises on the edge WIDTH+1 cycles after the start-accept edge (33 for WIDTH=32). Latency is the same for every operand, including zero.
- DONE:
  - q/r/wn/div0 are held stable while wb_ack=0, for an unbounded time.
  - On the edge with wb_ack=1, go to IDLE with valid=0. q/r/wn keep their last values; div0 clears.
  - start is ignored in DONE; a new start is accepted at the earliest one cycle after the ack.
- start while not IDLE: ignored, with no side effects.
- wb_ack while valid=0: ignored.
- wn=0 results still complete and handshake normally. Suppressing the write is the regfile's job, not this block's.
- No combinational path from inputs to outputs. All outputs are registered or decoded from state.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3.
  - WORD_W=32 and REG_W=5 constants, shared with regfile and the pipeline registers.
  - DIV0_Q constant (all ones).
- One natural combinational sub-module, div_step: one restoring iteration, taking {rem,quo,divisor} and returning {rem',quo'}. It is instantiated once and reused every cycle.

Test Plan:
- Unsigned 100/7, rd=5, start at cycle 0 -> ready=0 next cycle; valid=1 after exactly 33 cycles with q=14, r=2, wn=5, div0=0; hold wb_ack=0 for 10 cycles, outputs stable; wb_ack=1 -> valid=0, ready=1 next edge.
- Signed sign cases with a one-cycle ack each: -7/2 -> q=-3 (0xFFFFFFFD), r=-1; 7/-2 -> q=-3, r=1; -7/-2 -> q=3, r=-1; unsigned 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
- Boundaries: signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
- Divide by zero: signed and unsigned 1234/0 -> after 33 cycles q=0xFFFFFFFF, r=1234, div0=1.
- start pulsed during CALC and during DONE with different operands -> ignored; the original result is unchanged; the back-to-back start accepted one cycle after wb_ack computes correctly.
- clrn pulsed low mid-CALC (cycle 15) -> outputs immediately 0, valid=0, ready=1; a new 50/5 afterwards gives q=10, r=0 with full 33-cycle latency.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and widths used by the EX-stage divider,
// the register file and the pipeline registers.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  localparam logic [WORD_W-1:0] DIV0_Q = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_div_wb_if.sv
// Request/result bundle between the EX-stage divider and
// the issue / write-back logic around it.
interface seq_div_wb_if #(
  parameter int WIDTH = 32,
  parameter int RW    = 5
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [RW-1:0]    rd;
  logic             wb_ack;
  logic             ready;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [RW-1:0]    wn;
  logic             div0;

  modport master (
    output start, is_signed, dividend,
    output divisor, rd, wb_ack,
    input  ready, busy, valid,
    input  q, r, wn, div0
  );

  modport slave (
    input  start, is_signed, dividend,
    input  divisor, rd, wb_ack,
    output ready, busy, valid,
    output q, r, wn, div0
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on {rem,quo}
// against an unsigned divisor magnitude.
module div_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rsh;
  logic [WIDTH+1:0] diff;
  logic             ok;
  logic             unused_msb;

  // rsh keeps the bit shifted out of rem so large divisors stay exact
  always_comb begin
    rsh        = {rem_i, quo_i[WIDTH-1]};
    diff       = {1'b0, rsh} - {2'b0, dvs_i};
    ok         = ~diff[WIDTH+1];
    unused_msb = diff[WIDTH];
    if (ok) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rsh[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_div_wb.sv
// Iterative restoring divider in EX; holds its result
// until write-back grants the regfile write port.
module seq_div_wb
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int RW    = REG_W
) (
  input logic         clk,
  input logic         clrn,
  seq_div_wb_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [RW-1:0]    wn_q, wn_d;
  logic             div0_q, div0_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             sa, sb;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    sa      = bus.is_signed & bus.dividend[WIDTH-1];
    sb      = bus.is_signed & bus.divisor[WIDTH-1];
    dvd_mag = sa ? -bus.dividend : bus.dividend;
    dvs_mag = sb ? -bus.divisor : bus.divisor;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    q_d     = q_q;
    r_d     = r_q;
    wn_d    = wn_q;
    div0_d  = div0_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CALC;
          cnt_d   = CW'(WIDTH - 1);
          rem_d   = '0;
          quo_d   = dvd_mag;
          dvs_d   = dvs_mag;
          dvd_d   = bus.dividend;
          wn_d    = bus.rd;
          neg_q_d = sa ^ sb;
          neg_r_d = sa;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) state_d = FIX;
        else cnt_d = cnt_q - 1'b1;
      end
      FIX: begin
        state_d = DONE;
        valid_d = 1'b1;
        // zero magnitude only arises from a zero divisor
        if (dvs_q == '0) begin
          q_d    = WIDTH'($signed(DIV0_Q));
          r_d    = dvd_q;
          div0_d = 1'b1;
        end else begin
          q_d    = neg_q_q ? -quo_q : quo_q;
          r_d    = neg_r_q ? -rem_q : rem_q;
          div0_d = 1'b0;
        end
      end
      DONE: begin
        if (bus.wb_ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
          div0_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      wn_q    <= '0;
      div0_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      q_q     <= q_d;
      r_q     <= r_d;
      wn_q    <= wn_d;
      div0_q  <= div0_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q != IDLE);
  assign bus.valid = valid_q;
  assign bus.q     = q_q;
  assign bus.r     = r_q;
  assign bus.wn    = wn_q;
  assign bus.div0  = div0_q;

endmodule

// File: tb/tb_seq_div_wb.sv
// Directed and random checks of seq_div_wb against an
// arithmetic reference model.
module tb_seq_div_wb;

  logic clk;
  logic clrn;
  int   checks;
  int   errors;

  seq_div_wb_if #(.WIDTH(32), .RW(5)) bus ();

  seq_div_wb dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %0s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit sgn,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] eq,
                                output logic [31:0] er,
                                output logic ez);
    longint x, y;
    if (b == 0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
      ez = 1'b1;
    end else begin
      if (sgn) begin
        x = longint'($signed(a));
        y = longint'($signed(b));
      end else begin
        x = longint'({32'b0, a});
        y = longint'({32'b0, b});
      end
      eq = 32'(x / y);
      er = 32'(x % y);
      ez = 1'b0;
    end
  endfunction

  task automatic run_op(input bit sgn,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rdn,
                        input int hold,
                        input bit poke);
    logic [31:0] eq, er;
    logic        ez;
    int          n;
    model(sgn, a, b, eq, er, ez);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.rd        = rdn;
    tick();
    bus.start = 1'b0;
    chk("ready_drop", 32'(bus.ready), 32'd0);
    chk("busy_rise", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.valid && n < 40) begin
      bus.start  = poke && (n == 10);
      bus.wb_ack = poke && (n == 5);
      if (poke) begin
        bus.dividend  = ~a;
        bus.divisor   = b + 3;
        bus.is_signed = ~sgn;
        bus.rd        = ~rdn;
      end
      tick();
      n++;
    end
    bus.start  = 1'b0;
    bus.wb_ack = 1'b0;
    chk("latency", 32'(n), 32'd33);
    chk("q", bus.q, eq);
    chk("r", bus.r, er);
    chk("wn", 32'(bus.wn), 32'(rdn));
    chk("div0", 32'(bus.div0), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      bus.start = poke;
      tick();
      chk("hold_valid", 32'(bus.valid), 32'd1);
      chk("hold_q", bus.q, eq);
    end
    bus.start = 1'b0;
    if (hold > 0) begin
      chk("hold_r", bus.r, er);
      chk("hold_wn", 32'(bus.wn), 32'(rdn));
    end
    bus.wb_ack = 1'b1;
    tick();
    bus.wb_ack = 1'b0;
    chk("ack_valid", 32'(bus.valid), 32'd0);
    chk("ack_ready", 32'(bus.ready), 32'd1);
    chk("ack_div0", 32'(bus.div0), 32'd0);
    chk("ack_q_kept", bus.q, eq);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    clrn          = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.rd        = '0;
    bus.wb_ack    = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_q", bus.q, 32'd0);
    chk("rst_r", bus.r, 32'd0);
    chk("rst_wn", 32'(bus.wn), 32'd0);
    chk("rst_div0", 32'(bus.div0), 32'd0);
    tick();
    tick();
    clrn = 1'b1;
    tick();

    run_op(1'b0, 32'd100, 32'd7, 5'd5, 10, 1'b0);
    run_op(1'b1, -32'sd7, 32'd2, 5'd1, 0, 1'b0);
    run_op(1'b1, 32'd7, -32'sd2, 5'd2, 0, 1'b0);
    run_op(1'b1, -32'sd7, -32'sd2, 5'd3, 0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 5'd7, 0, 1'b0);
    run_op(1'b1, 32'd1234, 32'd0, 5'd8, 0, 1'b0);
    run_op(1'b0, 32'd1234, 32'd0, 5'd9, 0, 1'b0);
    run_op(1'b1, -32'sd1234, 32'd0, 5'd10, 0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 0, 1'b0);
    run_op(1'b0, 32'h7FFF_FFFF, 32'h8000_0001, 5'd11, 0, 1'b0);
    run_op(1'b0, 32'd999, 32'd10, 5'd12, 4, 1'b1);
    run_op(1'b1, -32'sd999, 32'd10, 5'd13, 0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9))
                                      : $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
      run_op(1'($urandom_range(0, 1)), a, b,
             5'($urandom_range(0, 31)), $urandom_range(0, 2), 1'b0);
    end

    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd77;
    bus.divisor   = 32'd3;
    bus.rd        = 5'd14;
    tick();
    bus.start = 1'b0;
    repeat (14) tick();
    clrn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_q", bus.q, 32'd0);
    chk("mid_rst_r", bus.r, 32'd0);
    chk("mid_rst_wn", 32'(bus.wn), 32'd0);
    tick();
    clrn = 1'b1;
    tick();
    run_op(1'b0, 32'd50, 32'd5, 5'd15, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
